// File: rtl/display_scheduler.sv
// display_scheduler: converts min/sec through a shared BCD converter and scans four 7-seg digits.
module display_scheduler #(
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       load,
  output logic [5:0] conv_data,
  input  logic [3:0] conv_bcd1,
  input  logic [3:0] conv_bcd0,
  output logic [3:0] an,
  output logic [3:0] digit,
  output logic       busy,
  output logic       done
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, SEL_SEC, CAP_SEC, CAP_MIN, COMMIT} state_t;
  state_t          state_q, state_d;
  logic            busy_q, busy_d, done_q, done_d, pend_q, pend_d;
  logic [5:0]      conv_q, conv_d, snap_s_q, snap_s_d, snap_m_q, snap_m_d;
  logic [3:0][3:0] sh_q, sh_d, disp_q, disp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d, digit_q, digit_d;
  logic            tick;
  function automatic logic [5:0] sat(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction
  assign tick = cnt_q == CW'(TICK_DIV - 1);
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pend_d   = pend_q;
    conv_d   = conv_q;
    snap_s_d = snap_s_q;
    snap_m_d = snap_m_q;
    sh_d     = sh_q;
    disp_d   = disp_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    an_d     = tick ? ~(4'b0001 << idx_q) : an_q;
    digit_d  = tick ? disp_q[idx_q] : digit_q;
    case (state_q)
      IDLE: if (load) begin
        snap_s_d = sat(sec_in);
        snap_m_d = sat(min_in);
        busy_d   = 1'b1;
        state_d  = SEL_SEC;
      end
      SEL_SEC: begin
        conv_d  = snap_s_q;
        pend_d  = pend_q | load;
        state_d = CAP_SEC;
      end
      CAP_SEC: begin
        sh_d[1] = conv_bcd1;
        sh_d[0] = conv_bcd0;
        conv_d  = snap_m_q;
        pend_d  = pend_q | load;
        state_d = CAP_MIN;
      end
      CAP_MIN: begin
        sh_d[3] = conv_bcd1;
        sh_d[2] = conv_bcd0;
        pend_d  = pend_q | load;
        state_d = COMMIT;
      end
      COMMIT: begin
        disp_d = sh_q;
        done_d = 1'b1;
        // a load arriving on the commit edge is serviced like a pending one
        if (pend_q | load) begin
          snap_s_d = sat(sec_in);
          snap_m_d = sat(min_in);
          pend_d   = 1'b0;
          state_d  = SEL_SEC;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
      conv_q   <= '0;
      snap_s_q <= '0;
      snap_m_q <= '0;
      sh_q     <= '0;
      disp_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= 4'b1111;
      digit_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
      conv_q   <= conv_d;
      snap_s_q <= snap_s_d;
      snap_m_q <= snap_m_d;
      sh_q     <= sh_d;
      disp_q   <= disp_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      digit_q  <= digit_d;
    end
  end
  assign conv_data = conv_q;
  assign an        = an_q;
  assign digit     = digit_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: random and directed stimulus checked against a cycle-level behavioural model.
module tb_display_scheduler;
  localparam int TD = 4;
  logic       clk, rst, load;
  logic [5:0] min_in, sec_in, conv_data;
  logic [3:0] conv_bcd1, conv_bcd0, an, digit;
  logic       busy, done;
  int vectors = 0, errs = 0;
  int m_cnt, m_idx, m_p, m_ss, m_sm, m_conv;
  int m_disp[4];
  logic [3:0] m_an, m_digit;
  logic m_busy, m_done, m_pend;

  display_scheduler #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .min_in(min_in), .sec_in(sec_in), .load(load),
    .conv_data(conv_data), .conv_bcd1(conv_bcd1), .conv_bcd0(conv_bcd0),
    .an(an), .digit(digit), .busy(busy), .done(done)
  );

  assign conv_bcd1 = 4'(conv_data / 6'd10);
  assign conv_bcd0 = 4'(conv_data % 6'd10);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  // p counts edges since a conversion job started; 0 means no job
  task automatic model_edge(input logic r, input logic l, input int s, input int m);
    if (r) begin
      m_cnt = 0; m_idx = 0; m_p = 0; m_ss = 0; m_sm = 0; m_conv = 0;
      for (int i = 0; i < 4; i++) m_disp[i] = 0;
      m_an = 4'b1111; m_digit = 0; m_busy = 0; m_done = 0; m_pend = 0;
      return;
    end
    if (m_cnt == TD - 1) begin
      m_an = ~(4'b0001 << m_idx);
      m_digit = 4'(m_disp[m_idx]);
      m_idx = (m_idx + 1) % 4;
    end
    m_cnt = (m_cnt + 1) % TD;
    m_done = 0;
    case (m_p)
      0: if (l) begin m_ss = sat(s); m_sm = sat(m); m_busy = 1; m_p = 1; end
      1: begin m_conv = m_ss; m_pend |= l; m_p = 2; end
      2: begin m_conv = m_sm; m_pend |= l; m_p = 3; end
      3: begin m_pend |= l; m_p = 4; end
      default: begin
        m_disp[0] = m_ss % 10; m_disp[1] = m_ss / 10;
        m_disp[2] = m_sm % 10; m_disp[3] = m_sm / 10;
        m_done = 1;
        if (m_pend || l) begin m_ss = sat(s); m_sm = sat(m); m_pend = 0; m_p = 1; end
        else begin m_busy = 0; m_p = 0; end
      end
    endcase
  endtask

  task automatic step(input logic r, input logic l, input int s, input int m);
    rst = r; load = l; sec_in = 6'(s); min_in = 6'(m);
    @(posedge clk);
    model_edge(r, l, s, m);
    #1;
    chk("an", an, m_an);
    chk("digit", digit, m_digit);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("conv_data", conv_data, m_conv);
  endtask

  // observe the next four scan ticks; exp holds the expected digit for scan index i at bits 4i+3:4i
  task automatic scan4(input string tag, input logic [15:0] exp, input int s, input int m);
    int gap, n, prev, pos;
    logic [3:0] pa;
    gap = 0; n = 0; prev = -1; pa = an;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step(0, 0, s, m);
      gap++;
      if (an != pa) begin
        pos = an == 4'b1110 ? 0 : an == 4'b1101 ? 1 : an == 4'b1011 ? 2 : an == 4'b0111 ? 3 : -1;
        chk({tag, "_onehot"}, pos >= 0, 1);
        chk({tag, "_digit"}, digit, exp[(pos & 3) * 4 +: 4]);
        if (prev >= 0) begin
          chk({tag, "_gap"}, gap, TD);
          chk({tag, "_order"}, pos, (prev + 1) % 4);
        end
        prev = pos; gap = 0; pa = an; n++;
      end
    end
    chk({tag, "_ticks"}, n, 4);
  endtask

  initial begin
    int dcnt;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_an", an, 4'b1111);
    chk("rst_digit", digit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_conv", conv_data, 0);
    scan4("idle_scan", 16'h0000, 0, 0);
    step(0, 1, 37, 12);
    step(0, 0, 37, 12); chk("c37", conv_data, 37);
    step(0, 0, 37, 12); chk("c12", conv_data, 12);
    step(0, 0, 37, 12); chk("c_nodone", done, 0);
    step(0, 0, 37, 12); chk("c_done", done, 1);
    step(0, 0, 37, 12); chk("c_done_pulse", done, 0);
    chk("c_idle", busy, 0);
    scan4("d3712", {4'd1, 4'd2, 4'd3, 4'd7}, 37, 12);
    step(0, 1, 63, 60);
    step(0, 0, 63, 60); chk("s_sec", conv_data, 59);
    step(0, 0, 63, 60); chk("s_min", conv_data, 59);
    step(0, 0, 63, 60);
    step(0, 0, 63, 60); chk("s_done", done, 1);
    scan4("dsat", {4'd5, 4'd9, 4'd5, 4'd9}, 63, 60);
    step(0, 1, 10, 20); chk("p_busy0", busy, 1);
    step(0, 0, 10, 20);
    step(0, 1, 45, 30);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 45, 30);
      dcnt += int'(done);
      if (i < 5) chk("p_busy", busy, 1);
    end
    chk("p_dones", dcnt, 2);
    scan4("dpend", {4'd3, 4'd0, 4'd4, 4'd5}, 45, 30);
    step(0, 1, 25, 41);
    step(0, 0, 25, 41);
    step(1, 0, 25, 41);
    chk("a_an", an, 4'b1111);
    chk("a_busy", busy, 0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 25, 41);
      dcnt += int'(done);
    end
    chk("a_nodone", dcnt, 0);
    scan4("dabort", 16'h0000, 25, 41);
    step(0, 1, 8, 21);
    for (int i = 0; i < 3; i++) step(0, 0, 8, 21);
    step(0, 0, 8, 21); chk("a_done", done, 1);
    scan4("dafter", {4'd2, 4'd1, 4'd0, 4'd8}, 8, 21);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 50000, the number of clk cycles per digit scan step (legal range >= 2).
REQ-002 SHALL provide port clk  input  1  the single system clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port min_in  input  6  binary minutes value.
REQ-005 SHALL provide port sec_in  input  6  binary seconds value.
REQ-006 SHALL provide port load  input  1  refresh request, sampled every edge.
REQ-007 SHALL provide port conv_data  output  6  registered operand to the shared binary-to-BCD converter.
REQ-008 SHALL provide port conv_bcd1  input  4  tens digit returned by the converter, combinational from conv_data.
REQ-009 SHALL provide port conv_bcd0  input  4  ones digit returned by the converter, combinational from conv_data.
REQ-010 SHALL provide port an  output  4  registered active-low one-hot digit enable.
REQ-011 SHALL provide port digit  output  4  registered BCD value of the enabled digit.
REQ-012 SHALL provide port busy  output  1  high while a conversion sequence is in progress.
REQ-013 SHALL provide port done  output  1  one-cycle pulse when the display registers commit.

Function
REQ-014 The FSM SHALL have states IDLE, SEL_SEC, CAP_SEC, CAP_MIN, COMMIT.
REQ-015 In IDLE with load=1 it SHALL: snapshot sec_in/min_in, saturating values >59 to 59; set busy=1; go to SEL_SEC.
REQ-016 SEL_SEC SHALL load conv_data with the seconds snapshot, then go to CAP_SEC.
REQ-017 CAP_SEC SHALL:
- capture conv_bcd1/conv_bcd0 into the seconds shadow tens/ones;
- load conv_data with the minutes snapshot;
- go to CAP_MIN.
REQ-018 CAP_MIN SHALL capture conv_bcd1/conv_bcd0 into the minutes shadow tens/ones, then go to COMMIT.
REQ-019 COMMIT SHALL copy all four shadow digits to the display registers in one edge and pulse done=1 for one cycle.
REQ-020 Latency: with load sampled at edge N in IDLE, done SHALL be high in the cycle after edge N+4, and the display registers SHALL update on that same edge N+4.
REQ-021 A load sampled while busy=1 SHALL set a pending flag; further loads while pending SHALL be absorbed (at most one pending).
REQ-022 In COMMIT with pending set, the block SHALL re-snapshot the inputs, clear pending, keep busy=1 and go to SEL_SEC; done still pulses.
REQ-023 In COMMIT with pending clear, the block SHALL set busy=0 and go to IDLE.
REQ-024 The display registers SHALL never show a partial update (no tearing between the seconds and minutes pairs).
REQ-025 Tick counter SHALL count 0..TICK_DIV-1 and wrap, producing a tick every TICK_DIV cycles independent of FSM state.
REQ-026 On each tick edge the block SHALL update, from the pre-tick scan index idx:
- an <= active-low decode of idx (0->1110, 1->1101, 2->1011, 3->0111);
- digit <= display register selected by idx;
- idx <= idx+1, wrapping 3->0.
REQ-027 Index mapping SHALL be 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens.
REQ-028 Exactly one an bit SHALL be low at any time after the first tick.

Reset
REQ-029 While rst=1 at an edge, the block SHALL set: FSM=IDLE, busy=0, done=0, pending=0, conv_data=0, snapshots/shadows/display registers=0, tick counter=0, idx=0, an=4'b1111, digit=0.
REQ-030 rst SHALL take priority over load and tick, and SHALL abort a conversion in progress with no done pulse.

Verification
REQ-031 Reset: assert rst 2 cycles -> an=1111, digit=0, busy=0, done=0, conv_data=0.
REQ-032 TICK_DIV=4; sec_in=37, min_in=12, load pulse at edge N:
- conv_data=37 then 12;
- done high after edge N+4;
- subsequent ticks show an/digit = 1110/7, 1101/3, 1011/2, 0111/1;
- ticks are exactly 4 cycles apart.
REQ-033 sec_in=63, min_in=60, load -> conv_data=59 then 59; digits 9,5,9,5.
REQ-034 load (sec=10, min=20), then load again 2 cycles later with sec=45, min=30:
- two done pulses;
- busy continuous;
- final display 5,4,0,3.
REQ-035 rst asserted in CAP_SEC -> no done pulse; display registers 0; FSM IDLE; a following load completes normally.
REQ-036 With no load after reset, scan runs: idx cycles 0->3->0, an rotates, digit=0 throughout.
